regfile_param: RTL and testbench

Parametrised general-purpose register file for the KGP-RISC datapath: two combinational read ports, one clocked write port, an optional hard-wired zero register, optional write-to-read bypass, and a debug tap on a selectable entry. A clear sequencer scrubs every entry without a full reset, one entry per cycle, while the decode stage keeps reading. It sits between the decode stage (read addresses) and the write-back stage (write port).

---
 rtl/regfile_param.sv | 112 +++++++++++
 tb/tb_regfile_param.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with two combinational read
// ports, one clocked write port, optional zero register, optional
// write-to-read bypass, a debug tap on one entry, and a scrub sequencer
// that clears one entry per cycle while reads continue.
//
// Write port handshake: wr_en is a request with no ready/backpressure. A
// request is accepted when the sequencer is IDLE and the target is not the
// hard-wired zero entry. A request made while busy is refused, and wr_drop
// pulses for one cycle afterwards. Zero-entry writes are discarded quietly.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int DBG_ADDR = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop,
  output logic [DATA_W-1:0] dbg_out
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] DBG_IDX = DBG_ADDR[ADDR_W-1:0];

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic                wr_to_zero;
  logic                wr_accept;

  assign wr_to_zero = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_accept  = wr_en && (state_q == IDLE) && !wr_to_zero;

  assign busy    = (state_q == CLEAR);
  assign wr_drop = wr_drop_q;

  // Read port 1: zero entry first, then bypass of an accepted write, else storage.
  always_comb begin
    rd_data1 = mem_q[rd_addr1];
    if ((BYPASS != 0) && wr_accept && (wr_addr == rd_addr1)) rd_data1 = wr_data;
    if ((ZERO_REG != 0) && (rd_addr1 == '0)) rd_data1 = '0;
  end

  // Read port 2: same priority as port 1, fully independent.
  always_comb begin
    rd_data2 = mem_q[rd_addr2];
    if ((BYPASS != 0) && wr_accept && (wr_addr == rd_addr2)) rd_data2 = wr_data;
    if ((ZERO_REG != 0) && (rd_addr2 == '0)) rd_data2 = '0;
  end

  // Debug tap shows stored contents only; never bypassed.
  always_comb begin
    dbg_out = mem_q[DBG_IDX];
    if ((ZERO_REG != 0) && (DBG_IDX == '0)) dbg_out = '0;
  end

  // Next-state: scrub sequencer, refused-write pulse, and storage update.
  always_comb begin
    mem_d     = mem_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_drop_d = 1'b0;
    if (state_q == CLEAR) begin
      // Clear one entry per cycle; the counter wraps to 0 on the last entry.
      mem_d[cnt_q] = '0;
      cnt_d        = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = IDLE;
      wr_drop_d    = wr_en;
    end else begin
      if (clr_req) begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    end
    // Only possible in IDLE, so it never collides with a scrub write.
    if (wr_accept) mem_d[wr_addr] = wr_data;
  end

  // State registers; reset clears storage and aborts any scrub.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: table-driven vectors plus hand-written scrub/reset
// sequences. Two instances share stimulus: u_dut with defaults (zero
// register and bypass on) and u_alt with both off.
module tb_regfile_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] rd_addr1, rd_addr2, wr_addr;
  logic          wr_en, clr_req;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data1, rd_data2, dbg_out;
  logic          busy, wr_drop;
  logic [DW-1:0] a_rd_data1, a_rd_data2, a_dbg_out;
  logic          a_busy, a_wr_drop;

  regfile_param u_dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy), .wr_drop(wr_drop), .dbg_out(dbg_out)
  );

  regfile_param #(.ZERO_REG(0), .BYPASS(0)) u_alt (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(a_rd_data1), .rd_data2(a_rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(a_busy), .wr_drop(a_wr_drop), .dbg_out(a_dbg_out)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_main [DEPTH];
  logic [DW-1:0] m_alt  [DEPTH];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic sb_check(input string name, input logic [DW-1:0] act);
    logic [DW-1:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got %h, no expectation queued", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", name, act, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    next_cycle();
    wr_en = 1'b0;
    m_alt[a] = d;
    if (a != 0) m_main[a] = d;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra1, ra2;
    logic [DW-1:0] e1, e2, edbg, ea1, ea2;
  } vec_t;

  vec_t vecs [9];
  logic [DW-1:0] d;

  initial begin
    // ---- vector table (expected values before the edge of each cycle) ----
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd5,  32'h12345678, 32'hDEADBEEF, 32'h0,        32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h0,        32'h12345678, 32'h0,        32'h0,        32'h12345678};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd12, 32'h0,        32'h0,        32'h0,        32'hFFFFFFFF, 32'h0};
    vecs[5] = '{1'b1, 5'd12, 32'hCAFEF00D, 5'd12, 5'd7,  32'hCAFEF00D, 32'h12345678, 32'h0,        32'h0,        32'h12345678};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd12, 5'd0,  32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 32'hFFFFFFFF};
    vecs[7] = '{1'b1, 5'd5,  32'h00000001, 5'd5,  5'd5,  32'h00000001, 32'h00000001, 32'hCAFEF00D, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h00000001, 32'h0,        32'hCAFEF00D, 32'h00000001, 32'h0};

    for (int i = 0; i < DEPTH; i++) begin m_main[i] = '0; m_alt[i] = '0; end
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    clr_req = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ---- reset state ----
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clk);
    sb_check("rst_busy", 32'(busy));
    sb_check("rst_drop", 32'(wr_drop));
    sb_check("rst_dbg", dbg_out);
    sb_check("rst_alt_busy", 32'(a_busy));
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr1 = AW'(a); rd_addr2 = AW'(DEPTH - 1 - a);
      exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
      #1;
      sb_check($sformatf("rst_rd1_%0d", a), rd_data1);
      sb_check($sformatf("rst_rd2_%0d", a), rd_data2);
      sb_check($sformatf("rst_alt_rd1_%0d", a), a_rd_data1);
    end
    next_cycle();

    // ---- table-driven vectors ----
    for (int i = 0; i < 9; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_addr1 = vecs[i].ra1; rd_addr2 = vecs[i].ra2;
      exp_q.push_back(vecs[i].e1);  exp_q.push_back(vecs[i].e2);
      exp_q.push_back(vecs[i].edbg); exp_q.push_back(vecs[i].edbg);
      exp_q.push_back(vecs[i].ea1); exp_q.push_back(vecs[i].ea2);
      exp_q.push_back(0);
      @(negedge clk);
      sb_check($sformatf("vec%0d_rd1", i), rd_data1);
      sb_check($sformatf("vec%0d_rd2", i), rd_data2);
      sb_check($sformatf("vec%0d_dbg", i), dbg_out);
      sb_check($sformatf("vec%0d_alt_dbg", i), a_dbg_out);
      sb_check($sformatf("vec%0d_alt_rd1", i), a_rd_data1);
      sb_check($sformatf("vec%0d_alt_rd2", i), a_rd_data2);
      sb_check($sformatf("vec%0d_drop", i), 32'(wr_drop));
      next_cycle();
      if (vecs[i].we) begin
        m_alt[vecs[i].wa] = vecs[i].wd;
        if (vecs[i].wa != 0) m_main[vecs[i].wa] = vecs[i].wd;
      end
    end
    wr_en = 1'b0;

    // ---- fill every entry with random nonzero data ----
    for (int i = 0; i < DEPTH; i++) begin
      d = 32'h8000_0000 | 32'($urandom_range(1, 32'h00FF_FFFF));
      do_write(AW'(i), d);
    end

    // ---- scrub, with a refused write at scrub cycle 10 ----
    clr_req = 1'b1;
    exp_q.push_back(0);
    @(negedge clk);
    sb_check("clr_sample_busy", 32'(busy));
    next_cycle();
    clr_req = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      rd_addr2 = AW'(k);
      if (k == 10) begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAA; rd_addr1 = 5'd3;
      end else begin
        wr_en = 1'b0; rd_addr1 = 5'd31;
      end
      exp_q.push_back(1); exp_q.push_back(1);
      exp_q.push_back(m_main[12]);
      exp_q.push_back(m_main[rd_addr1]); exp_q.push_back(m_main[k]);
      exp_q.push_back(m_alt[rd_addr1]);  exp_q.push_back(m_alt[k]);
      exp_q.push_back((k == 11) ? 32'd1 : 32'd0);
      @(negedge clk);
      sb_check($sformatf("scrub%0d_busy", k), 32'(busy));
      sb_check($sformatf("scrub%0d_alt_busy", k), 32'(a_busy));
      sb_check($sformatf("scrub%0d_dbg", k), dbg_out);
      sb_check($sformatf("scrub%0d_rd1", k), rd_data1);
      sb_check($sformatf("scrub%0d_rd2", k), rd_data2);
      sb_check($sformatf("scrub%0d_alt_rd1", k), a_rd_data1);
      sb_check($sformatf("scrub%0d_alt_rd2", k), a_rd_data2);
      sb_check($sformatf("scrub%0d_drop", k), 32'(wr_drop));
      next_cycle();
      m_main[k] = '0; m_alt[k] = '0;
    end

    // ---- first write accepted in the cycle busy falls ----
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; rd_addr1 = 5'd9; rd_addr2 = 5'd3;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(32'h99);
    exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clk);
    sb_check("post_busy", 32'(busy));
    sb_check("post_drop", 32'(wr_drop));
    sb_check("post_bypass_rd1", rd_data1);
    sb_check("post_alt_rd1", a_rd_data1);
    sb_check("post_rd2", rd_data2);
    next_cycle();
    wr_en = 1'b0;
    m_main[9] = 32'h99; m_alt[9] = 32'h99;

    // ---- all entries scrubbed (except the fresh write) ----
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr1 = AW'(a); rd_addr2 = AW'(DEPTH - 1 - a);
      exp_q.push_back(m_main[a]); exp_q.push_back(m_main[DEPTH - 1 - a]);
      exp_q.push_back(m_alt[a]);
      #1;
      sb_check($sformatf("clean_rd1_%0d", a), rd_data1);
      sb_check($sformatf("clean_rd2_%0d", a), rd_data2);
      sb_check($sformatf("clean_alt_rd1_%0d", a), a_rd_data1);
    end
    next_cycle();

    // ---- reset in the middle of a scrub ----
    do_write(5'd20, 32'h20);
    do_write(5'd31, 32'h31);
    clr_req = 1'b1;
    next_cycle();
    clr_req = 1'b0;
    repeat (8) next_cycle();
    rst = 1'b1;
    exp_q.push_back(1);
    @(negedge clk);
    sb_check("mid_busy_before_rst", 32'(busy));
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin m_main[i] = '0; m_alt[i] = '0; end
    rd_addr1 = 5'd20; rd_addr2 = 5'd31;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clk);
    sb_check("mid_rst_busy", 32'(busy));
    sb_check("mid_rst_r20", rd_data1);
    sb_check("mid_rst_r31", rd_data2);
    sb_check("mid_rst_alt_r31", a_rd_data2);
    rd_addr1 = 5'd9;
    exp_q.push_back(0);
    #1;
    sb_check("mid_rst_r9", rd_data1);
    next_cycle();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44; rd_addr1 = 5'd4;
    exp_q.push_back(32'h44); exp_q.push_back(0);
    @(negedge clk);
    sb_check("after_rst_bypass", rd_data1);
    sb_check("after_rst_busy", 32'(busy));
    next_cycle();
    wr_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(32'h44); exp_q.push_back(0);
      @(negedge clk);
      sb_check($sformatf("after_rst_r4_%0d", c), rd_data1);
      sb_check($sformatf("after_rst_idle_%0d", c), 32'(busy));
      next_cycle();
    end

    // ---- reset and clr_req together: reset wins ----
    rst = 1'b1; clr_req = 1'b1;
    next_cycle();
    rst = 1'b0; clr_req = 1'b0;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clk);
    sb_check("rst_clr_busy", 32'(busy));
    sb_check("rst_clr_alt_busy", 32'(a_busy));
    sb_check("rst_clr_r4", rd_data1);
    next_cycle();

    // ---- final report ----
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL leftover_expectations: got %0d queued, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
